// File: rtl/seven_segment_reader.sv
// Reconstructs hex nibbles from a multiplexed active-low seven-segment bus.
// Each digit dwell must hold steady for STABLE_CYCLES samples before it is committed once.
module seven_segment_reader #(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_DIGITS-1:0]   anode,
   input  logic [6:0]              segment,
   input  logic                    clear_err,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    update,
   output logic [2:0]              upd_index,
   output logic                    err_sticky
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] TRACK  = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;
   localparam logic [1:0] HOLD   = 2'd3;

   localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES);
   localparam logic [6:0] BLANK       = 7'h7F;

   logic [NUM_DIGITS-1:0] anode_p0, anode_p1;
   logic [6:0]            seg_p0, seg_p1;
   logic [1:0]            state, state_nxt;
   logic [7:0]            cnt, cnt_nxt;
   logic                  commit;
   logic                  single, same;
   logic [2:0]            idx;
   logic [4:0]            glyph;

   // Returns {recognised, nibble}; unrecognised codes return 0.
   function automatic logic [4:0] decode_glyph(input logic [6:0] s);
      case (s)
         7'h40:   decode_glyph = 5'h10;
         7'h79:   decode_glyph = 5'h11;
         7'h24:   decode_glyph = 5'h12;
         7'h30:   decode_glyph = 5'h13;
         7'h19:   decode_glyph = 5'h14;
         7'h12:   decode_glyph = 5'h15;
         7'h02:   decode_glyph = 5'h16;
         7'h78:   decode_glyph = 5'h17;
         7'h00:   decode_glyph = 5'h18;
         7'h10:   decode_glyph = 5'h19;
         7'h08:   decode_glyph = 5'h1A;
         7'h03:   decode_glyph = 5'h1B;
         7'h46:   decode_glyph = 5'h1C;
         7'h21:   decode_glyph = 5'h1D;
         7'h06:   decode_glyph = 5'h1E;
         7'h0E:   decode_glyph = 5'h1F;
         default: decode_glyph = 5'h00;
      endcase
   endfunction

   function automatic logic is_single(input logic [NUM_DIGITS-1:0] a);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) n = n + {3'b000, ~a[i]};
      return n == 4'd1;
   endfunction

   function automatic logic [2:0] zero_index(input logic [NUM_DIGITS-1:0] a);
      logic [2:0] z;
      z = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) if (!a[i]) z = 3'(i);
      return z;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   assign single = is_single(anode_p0);
   assign same   = (anode_p0 == anode_p1) && (seg_p0 == seg_p1);
   assign idx    = zero_index(anode_p0);
   assign glyph  = decode_glyph(seg_p0);

   // The commit is decided on the edge where the run reaches STABLE_CYCLES,
   // so the outputs land on that same edge; COMMIT then just marks the dwell.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (single) begin
               state_nxt = TRACK;
               cnt_nxt   = 8'd1;
            end else begin
               cnt_nxt = 8'd0;
            end
         end
         TRACK: begin
            if (!single) begin
               state_nxt = IDLE;
               cnt_nxt   = 8'd0;
            end else if (!same) begin
               cnt_nxt = 8'd1;
            end else if (cnt + 8'd1 == STABLE_LAST) begin
               state_nxt = COMMIT;
               cnt_nxt   = sat_inc(cnt);
               commit    = 1'b1;
            end else begin
               cnt_nxt = sat_inc(cnt);
            end
         end
         default: begin
            if (!single) begin
               state_nxt = IDLE;
               cnt_nxt   = 8'd0;
            end else if (!same) begin
               state_nxt = TRACK;
               cnt_nxt   = 8'd1;
            end else begin
               state_nxt = HOLD;
               cnt_nxt   = sat_inc(cnt);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         anode_p0    <= '0;
         seg_p0      <= '0;
         anode_p1    <= '0;
         seg_p1      <= '0;
         state       <= IDLE;
         cnt         <= 8'd0;
         digits      <= '0;
         digit_valid <= '0;
         update      <= 1'b0;
         upd_index   <= 3'd0;
         err_sticky  <= 1'b0;
      end else begin
         anode_p0 <= anode;
         seg_p0   <= segment;
         anode_p1 <= anode_p0;
         seg_p1   <= seg_p0;
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         update   <= commit;
         if (commit) begin
            upd_index <= idx;
            if (glyph[4]) begin
               digits[idx*4 +: 4] <= glyph[3:0];
               digit_valid[idx]   <= 1'b1;
            end else begin
               digit_valid[idx]   <= 1'b0;
            end
         end
         if (commit && !glyph[4] && seg_p0 != BLANK) err_sticky <= 1'b1;
         else if (clear_err)                         err_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: directed vector table, reset corner case,
// and randomized dwells against a run-length reference model.
module tb_seven_segment_reader;

   localparam int ND = 8;
   localparam int S  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [ND-1:0] anode;
   logic [6:0]    segment;
   logic          clear_err;
   logic [31:0]   digits;
   logic [ND-1:0] digit_valid;
   logic          update;
   logic [2:0]    upd_index;
   logic          err_sticky;

   seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
      .clk(clk), .reset(reset), .anode(anode), .segment(segment),
      .clear_err(clear_err), .digits(digits), .digit_valid(digit_valid),
      .update(update), .upd_index(upd_index), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int tests = 0;
   int fails = 0;

   // Reference model: a dwell is committed once its run of identical samples
   // reaches exactly S; outputs appear on the following edge.
   logic [31:0]   m_digits;
   logic [ND-1:0] m_valid;
   logic          m_update;
   logic [2:0]    m_idx;
   logic          m_err;
   logic [ND-1:0] last_an;
   logic [6:0]    last_seg;
   logic          last_ok;
   int            run;

   function automatic int zero_count(input logic [ND-1:0] a);
      int n = 0;
      for (int i = 0; i < ND; i++) if (a[i] == 1'b0) n++;
      return n;
   endfunction

   task automatic model_clear();
      m_digits = '0; m_valid = '0; m_update = 1'b0; m_idx = 3'd0; m_err = 1'b0;
      last_an = '0; last_seg = '0; last_ok = 1'b0; run = 0;
   endtask

   task automatic model_step();
      logic bad;
      int   pos;
      int   hit;
      bad = 1'b0;
      m_update = 1'b0;
      if (last_ok && run == S && zero_count(last_an) == 1) begin
         pos = 0;
         for (int i = 0; i < ND; i++) if (!last_an[i]) pos = i;
         hit = -1;
         for (int g = 0; g < 16; g++) if (glyph_tab[g] == last_seg) hit = g;
         m_update = 1'b1;
         m_idx    = 3'(pos);
         if (hit >= 0) begin
            m_digits[pos*4 +: 4] = 4'(hit);
            m_valid[pos] = 1'b1;
         end else begin
            m_valid[pos] = 1'b0;
            if (last_seg != 7'h7F) bad = 1'b1;
         end
      end
      if (bad) m_err = 1'b1;
      else if (clear_err) m_err = 1'b0;
      if (last_ok && anode == last_an && segment == last_seg) begin
         if (run < 100000) run++;
      end else begin
         last_an = anode; last_seg = segment; last_ok = 1'b1; run = 1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      check("digits", digits, m_digits);
      check("digit_valid", 32'(digit_valid), 32'(m_valid));
      check("update", 32'(update), 32'(m_update));
      check("upd_index", 32'(upd_index), 32'(m_idx));
      check("err_sticky", 32'(err_sticky), 32'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic apply(input logic [ND-1:0] an, input logic [6:0] sg, input logic clr,
                        input int n, output int upds, output int first);
      anode = an; segment = sg; clear_err = clr;
      upds = 0; first = 0;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (update === 1'b1) begin
            upds++;
            if (first == 0) first = i;
         end
      end
   endtask

   typedef struct {
      logic [ND-1:0] an;
      logic [6:0]    seg;
      logic          clr;
      int            dwell;
      logic [31:0]   exp_digits;
      logic [ND-1:0] exp_valid;
      logic          exp_err;
      int            exp_upd;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int          u, f, total;
      logic [31:0] ed;
      logic [ND-1:0] ev;

      vecs.push_back('{8'hFE, 7'h30, 1'b0, 10, 32'h0000_0003, 8'h01, 1'b0, 1});
      for (int i = 0; i < 8; i++) begin
         ed = '0;
         for (int j = 0; j <= i; j++) ed[j*4 +: 4] = 4'(j);
         ev = 8'((16'd1 << (i + 1)) - 16'd1);
         vecs.push_back('{~(8'd1 << i), glyph_tab[i], 1'b0, 6, ed, ev, 1'b0, 1});
      end
      vecs.push_back('{8'hFB, 7'h7F, 1'b0, 6, 32'h7654_3210, 8'hFB, 1'b0, 1});
      vecs.push_back('{8'hFB, 7'h55, 1'b0, 6, 32'h7654_3210, 8'hFB, 1'b1, 1});
      vecs.push_back('{8'hFB, 7'h55, 1'b1, 3, 32'h7654_3210, 8'hFB, 1'b0, 0});
      vecs.push_back('{8'hF0, 7'h00, 1'b0, 20, 32'h7654_3210, 8'hFB, 1'b0, 0});
      vecs.push_back('{8'hFF, 7'h00, 1'b0, 20, 32'h7654_3210, 8'hFB, 1'b0, 0});

      reset = 1'b1; anode = '1; segment = 7'h7F; clear_err = 1'b0;
      model_clear();
      #2;
      check_all();
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed table; the scan portion must issue exactly eight commits.
      total = 0;
      foreach (vecs[k]) begin
         apply(vecs[k].an, vecs[k].seg, vecs[k].clr, vecs[k].dwell, u, f);
         check($sformatf("vec%0d_digits", k), digits, vecs[k].exp_digits);
         check($sformatf("vec%0d_valid", k), 32'(digit_valid), 32'(vecs[k].exp_valid));
         check($sformatf("vec%0d_err", k), 32'(err_sticky), 32'(vecs[k].exp_err));
         check($sformatf("vec%0d_updates", k), u, vecs[k].exp_upd);
         if (vecs[k].exp_upd == 1) check($sformatf("vec%0d_latency", k), f, S + 1);
         if (k >= 1 && k <= 8) total += u;
      end
      check("scan_update_count", total, 8);

      // Glitching segments on digit 1, then a stable 6.
      total = 0;
      for (int t = 0; t < 6; t++) begin
         apply(8'hFD, (t % 2 == 0) ? 7'h12 : 7'h02, 1'b0, 2, u, f);
         total += u;
      end
      check("toggle_no_commit", total, 0);
      apply(8'hFD, 7'h02, 1'b0, 8, u, f);
      check("toggle_then_commit", u, 1);
      check("toggle_digits", digits, 32'h7654_3260);
      check("toggle_index", 32'(upd_index), 32'd1);

      // Reset in the middle of a dwell, then full requalification.
      apply(8'hEF, 7'h0E, 1'b0, 3, u, f);
      check("pre_reset_no_commit", u, 0);
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      check_all();
      check("reset_digits_zero", digits, 32'h0);
      @(posedge clk); #1;
      check("reset_no_update", 32'(update), 32'd0);
      reset = 1'b0;
      apply(8'hEF, 7'h0E, 1'b0, 10, u, f);
      check("post_reset_updates", u, 1);
      check("post_reset_latency", f, S + 1);
      check("post_reset_digits", digits, 32'h000F_0000);
      check("post_reset_valid", 32'(digit_valid), 32'h10);

      // Randomized dwells checked cycle by cycle against the model.
      for (int r = 0; r < 150; r++) begin
         logic [ND-1:0] an;
         logic [6:0]    sg;
         int            kind, sk;
         kind = $urandom_range(0, 9);
         if (kind == 0) an = '1;
         else if (kind == 1) an = ~(8'h03 << $urandom_range(0, 6));
         else an = ~(8'd1 << $urandom_range(0, 7));
         sk = $urandom_range(0, 19);
         if (sk < 16) sg = glyph_tab[sk];
         else if (sk < 18) sg = 7'h7F;
         else sg = 7'($urandom);
         apply(an, sg, ($urandom_range(0, 15) == 0), $urandom_range(1, 7), u, f);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
